// File: rtl/wb_master_pkg.sv
// Shared types and bus widths for the Wishbone classic single-transfer initiator.
package wb_master_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_master_timeout.sv
// Bus-hang watchdog: counts stalled strobe cycles and flags the last allowed one.
// TIMEOUT_CYCLES=0 ties the terminal-count output low.
module wb_master_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              TC_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TC_INT);

    logic [CNT_W-1:0] cnt_r;

    // Stall counter; clear has priority so a fresh attempt always starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (TIMEOUT_CYCLES != 0) ? (cnt_r == TC_VAL) : 1'b0;

endmodule

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: one outstanding transfer from a valid/ready command
// stream, with timeout abort. Optional reissue-on-timeout via WB_MASTER_PORT_RETRY_EN.
module wb_master_port
    import wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int MAX_RETRY      = 2
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
`ifdef WB_MASTER_PORT_RETRY_EN
    ,
    output logic [1:0]          rsp_retries_o
`endif
);

    wb_state_t           state_r;
    logic                cmd_ready_r;
    logic                rsp_valid_r;
    wb_rsp_t             rsp_r;
    logic                cyc_r;
    logic                stb_r;
    logic                we_r;
    logic [WB_ADR_W-1:0] adr_r;
    logic [WB_DAT_W-1:0] dat_r;
    logic [WB_SEL_W-1:0] sel_r;
`ifdef WB_MASTER_PORT_RETRY_EN
    logic [1:0]          retries_r;
`endif

    logic accept_s;
    logic tmo_clr_s;
    logic tmo_en_s;
    logic tmo_tc_s;

    assign accept_s  = (state_r == IDLE) && cmd_valid_i && cmd_ready_r;
    // A BUS cycle with cyc low is the retry gap; reissue restarts the count.
    assign tmo_clr_s = accept_s || ((state_r == BUS) && !cyc_r);
    assign tmo_en_s  = (state_r == BUS) && cyc_r && !wbm_ack_i;

    wb_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .clr   (tmo_clr_s),
        .en    (tmo_en_s),
        .tc    (tmo_tc_s)
    );

    // Transfer FSM; every output is a register updated here.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_r       <= '{dat: '0, err: 1'b0};
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= '0;
            dat_r       <= '0;
            sel_r       <= '0;
`ifdef WB_MASTER_PORT_RETRY_EN
            retries_r   <= 2'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r        <= cmd_we_i;
                        adr_r       <= cmd_adr_i;
                        dat_r       <= cmd_dat_i;
                        sel_r       <= cmd_sel_i;
                        cyc_r       <= 1'b1;
                        stb_r       <= 1'b1;
                        cmd_ready_r <= 1'b0;
`ifdef WB_MASTER_PORT_RETRY_EN
                        retries_r   <= 2'd0;
`endif
                        state_r     <= BUS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUS: begin
                    if (cyc_r && wbm_ack_i) begin
                        // Ack beats a same-cycle terminal count.
                        rsp_r.dat   <= we_r ? {WB_DAT_W{1'b0}} : wbm_dat_i;
                        rsp_r.err   <= 1'b0;
                        cyc_r       <= 1'b0;
                        stb_r       <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
                    end else if (cyc_r && tmo_tc_s) begin
                        cyc_r <= 1'b0;
                        stb_r <= 1'b0;
`ifdef WB_MASTER_PORT_RETRY_EN
                        if (int'(retries_r) < MAX_RETRY) begin
                            retries_r <= retries_r + 2'd1;
                            state_r   <= BUS;
                        end else begin
                            rsp_r       <= '{dat: '0, err: 1'b1};
                            rsp_valid_r <= 1'b1;
                            state_r     <= RESP;
                        end
`else
                        rsp_r       <= '{dat: '0, err: 1'b1};
                        rsp_valid_r <= 1'b1;
                        state_r     <= RESP;
`endif
                    end else if (!cyc_r) begin
                        cyc_r   <= 1'b1;
                        stb_r   <= 1'b1;
                        state_r <= BUS;
                    end else begin
                        state_r <= BUS;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cmd_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                    cyc_r       <= 1'b0;
                    stb_r       <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_dat_o   = rsp_r.dat;
    assign rsp_err_o   = rsp_r.err;
    assign wbm_cyc_o   = cyc_r;
    assign wbm_stb_o   = stb_r;
    assign wbm_we_o    = we_r;
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = dat_r;
    assign wbm_sel_o   = sel_r;
`ifdef WB_MASTER_PORT_RETRY_EN
    assign rsp_retries_o = retries_r;
`endif

endmodule
